// File: rtl/cla_share_arbiter.sv
// Round-robin controller sharing one pipelined CLA adder among NUM_REQ requesters.
// Optional macro CLA_SHARE_CARRY_EN: register the adder carry-out onto rsp_co.
module cla_share_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 16,
  parameter int ADDER_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_ci,
  input  logic [WIDTH-1:0]         add_s,
  input  logic                     add_co,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_co,
  output logic                     busy
);
  localparam int TAG_W = $clog2(NUM_REQ);
  localparam int LAST  = ADDER_LAT - 1;

  logic [TAG_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 grant_vld;
  logic [TAG_W-1:0]     grant_idx;
  int                   srch_idx;
  logic [ADDER_LAT-1:0] tag_vld_q;
  logic [TAG_W-1:0]     tag_q [ADDER_LAT];
  logic                 rsp_fire;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]     rsp_sum_q, rsp_sum_d;

  // Grant search starts at rr_ptr and wraps; the winner's operands go straight to the adder.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    srch_idx  = 0;
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    if (en && !rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        srch_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
        if (!grant_vld && req_valid[srch_idx]) begin
          grant_vld           = 1'b1;
          grant_idx           = TAG_W'(srch_idx);
          req_ready[srch_idx] = 1'b1;
          add_a               = req_a[srch_idx*WIDTH +: WIDTH];
          add_b               = req_b[srch_idx*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign add_ci = 1'b0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) begin
      rr_ptr_d = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  // Shadow tag pipeline: advances with the adder's en so tags line up with add_s.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
    end else if (en) begin
      tag_vld_q[0] <= grant_vld;
      for (int k = 1; k < ADDER_LAT; k++) tag_vld_q[k] <= tag_vld_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      tag_q[0] <= grant_idx;
      for (int k = 1; k < ADDER_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign busy     = |tag_vld_q;
  assign rsp_fire = en && tag_vld_q[LAST];

  // Response stage: one-cycle owner pulse, sum held until the next result.
  always_comb begin
    rsp_valid_d = '0;
    rsp_sum_d   = rsp_sum_q;
    if (rsp_fire) begin
      rsp_valid_d[tag_q[LAST]] = 1'b1;
      rsp_sum_d                = add_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_sum_q   <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;

`ifdef CLA_SHARE_CARRY_EN
  logic rsp_co_q, rsp_co_d;

  always_comb begin
    rsp_co_d = rsp_co_q;
    if (rsp_fire) rsp_co_d = add_co;
  end

  always_ff @(posedge clk) begin
    if (rst) rsp_co_q <= 1'b0;
    else     rsp_co_q <= rsp_co_d;
  end

  assign rsp_co = rsp_co_q;
`else
  logic unused_add_co;
  assign unused_add_co = add_co;
  assign rsp_co        = 1'b0;
`endif

endmodule
